// File: rtl/chart_sequencer_pkg.sv
// Shared definitions for the chart playback sequencer.
package chart_sequencer_pkg;

  localparam int unsigned LANES        = 5;
  localparam int unsigned DEF_TICK_DIV = 13500000;
  localparam int unsigned LOOP_W       = 8;

  typedef logic [LANES-1:0] lanes_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/chart_sequencer_tick_gen.sv
// Eighth-note tick divider: counts 0..TICK_DIV-1 while enabled, tick on the last count.
module chart_sequencer_tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick_c = en && (cnt == CNT_LAST);

  // Divider counter; clr wins over en, wraps to zero on the tick.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick_c ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/chart_sequencer.sv
// Chart playback controller: steps a chart position on eighth-note ticks, fetches
// each lane pattern from an external synchronous ROM and presents it with a strobe.
module chart_sequencer
  import chart_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
  parameter int unsigned CHART_LEN = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned LOOPS     = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  output logic [ADDR_W-1:0] chart_addr,
  input  logic [LANES-1:0]  chart_data,
  output logic [LANES-1:0]  exp_notes,
  output logic              note_strobe,
  output logic              playing,
  output logic              done,
  output logic [ADDR_W-1:0] beat_pos
);

  localparam logic [ADDR_W-1:0] POS_LAST   = ADDR_W'(CHART_LEN - 1);
  localparam logic [LOOP_W-1:0] LOOPS_INIT = LOOP_W'(LOOPS);

  state_t            state;
  logic [ADDR_W-1:0] pos;
  logic [LOOP_W-1:0] loops_left;
  logic              fetch_p1;
  logic              fetch_p2;

  logic              tick_c;
  logic              div_en_c;
  logic              begin_c;
  logic              div_clr_c;

  // Command decode: stop beats pause beats start.
  assign begin_c   = start && !pause && !stop && ((state == S_IDLE) || (state == S_DONE));
  assign div_en_c  = (state == S_PLAY) && !pause && !stop;
  assign div_clr_c = stop || begin_c;

  chart_sequencer_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .resetn (resetn),
    .en     (div_en_c),
    .clr    (div_clr_c),
    .tick_c (tick_c)
  );

  // Playback FSM, position/loop counters and the two-stage ROM fetch pipe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      pos         <= '0;
      loops_left  <= '0;
      fetch_p1    <= 1'b0;
      fetch_p2    <= 1'b0;
      chart_addr  <= '0;
      exp_notes   <= '0;
      note_strobe <= 1'b0;
      beat_pos    <= '0;
      playing     <= 1'b0;
      done        <= 1'b0;
    end else begin
      note_strobe <= 1'b0;
      fetch_p1    <= 1'b0;
      fetch_p2    <= fetch_p1;

      // ROM data for the address issued two edges ago is valid now.
      if (fetch_p2) begin
        exp_notes   <= chart_data;
        beat_pos    <= chart_addr;
        note_strobe <= 1'b1;
      end

      if (stop) begin
        state       <= S_IDLE;
        pos         <= '0;
        loops_left  <= '0;
        fetch_p1    <= 1'b0;
        fetch_p2    <= 1'b0;
        chart_addr  <= '0;
        exp_notes   <= '0;
        note_strobe <= 1'b0;
        beat_pos    <= '0;
        playing     <= 1'b0;
        done        <= 1'b0;
      end else if (pause) begin
        if (state == S_PLAY) begin
          state   <= S_PAUSED;
          playing <= 1'b0;
        end
      end else if (begin_c) begin
        state      <= S_PLAY;
        playing    <= 1'b1;
        done       <= 1'b0;
        pos        <= '0;
        loops_left <= LOOPS_INIT;
        chart_addr <= '0;
        fetch_p1   <= 1'b1;
      end else if (start && (state == S_PAUSED)) begin
        state   <= S_PLAY;
        playing <= 1'b1;
      end else if (tick_c) begin
        if (pos < POS_LAST) begin
          pos        <= pos + ADDR_W'(1);
          chart_addr <= pos + ADDR_W'(1);
          fetch_p1   <= 1'b1;
        end else if ((LOOPS == 0) || (loops_left > LOOP_W'(1))) begin
          pos        <= '0;
          chart_addr <= '0;
          fetch_p1   <= 1'b1;
          if (loops_left != '0) begin
            loops_left <= loops_left - LOOP_W'(1);
          end
        end else begin
          state     <= S_DONE;
          playing   <= 1'b0;
          done      <= 1'b1;
          exp_notes <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_chart_sequencer.sv
// Bench for chart_sequencer: three instances (LOOPS = 1, 2, 0) share the controls and
// are compared every cycle against a behavioural playback model.
module tb_chart_sequencer;

  localparam int unsigned TD  = 4;
  localparam int unsigned LEN = 4;
  localparam int unsigned AW  = 2;
  localparam int unsigned NI  = 3;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic start  = 1'b0;
  logic pause  = 1'b0;
  logic stop   = 1'b0;

  logic [AW-1:0] addr_w  [NI];
  logic [4:0]    data_w  [NI];
  logic [4:0]    exp_w   [NI];
  logic          strb_w  [NI];
  logic          play_w  [NI];
  logic          done_w  [NI];
  logic [AW-1:0] bpos_w  [NI];

  logic [4:0] rom [LEN];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned LP = (g == 0) ? 1 : ((g == 1) ? 2 : 0);

    chart_sequencer #(
      .TICK_DIV  (TD),
      .CHART_LEN (LEN),
      .ADDR_W    (AW),
      .LOOPS     (LP)
    ) u_dut (
      .clk         (clk),
      .resetn      (resetn),
      .start       (start),
      .pause       (pause),
      .stop        (stop),
      .chart_addr  (addr_w[g]),
      .chart_data  (data_w[g]),
      .exp_notes   (exp_w[g]),
      .note_strobe (strb_w[g]),
      .playing     (play_w[g]),
      .done        (done_w[g]),
      .beat_pos    (bpos_w[g])
    );

    // Synchronous chart ROM, one clock of read latency.
    always @(posedge clk) data_w[g] <= rom[addr_w[g]];
  end

  // Behavioural model: mode 0 idle, 1 play, 2 paused, 3 done.
  int loops_cfg [NI] = '{1, 2, 0};
  int m_mode [NI];
  int m_pos [NI];
  int m_pass [NI];
  int m_since [NI];
  int m_exp [NI];
  int m_strobe [NI];
  int m_bpos [NI];
  int m_addr [NI];
  int m_pv [NI];
  int m_pat [NI];
  int m_ppos [NI];
  int edge_n = 0;

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_mode[i] = 0; m_pos[i] = 0; m_pass[i] = 0; m_since[i] = 0;
      m_exp[i] = 0; m_strobe[i] = 0; m_bpos[i] = 0; m_addr[i] = 0;
      m_pv[i] = 0; m_pat[i] = 0; m_ppos[i] = 0;
    end
  endtask

  task automatic issue(input int i, input int p);
    m_addr[i] = p;
    m_pv[i]   = 1;
    m_pat[i]  = edge_n + 2;
    m_ppos[i] = p;
  endtask

  task automatic model_edge();
    edge_n++;
    if (!resetn) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NI; i++) begin
      m_strobe[i] = 0;
      if (m_pv[i] != 0 && m_pat[i] == edge_n) begin
        m_pv[i]     = 0;
        m_exp[i]    = int'(rom[m_ppos[i]]);
        m_bpos[i]   = m_ppos[i];
        m_strobe[i] = 1;
      end
      if (stop) begin
        m_mode[i] = 0; m_pos[i] = 0; m_pass[i] = 0; m_since[i] = 0;
        m_exp[i] = 0; m_strobe[i] = 0; m_bpos[i] = 0; m_addr[i] = 0; m_pv[i] = 0;
      end else if (pause) begin
        if (m_mode[i] == 1) m_mode[i] = 2;
      end else if (start && (m_mode[i] == 0 || m_mode[i] == 3)) begin
        m_mode[i]  = 1;
        m_pos[i]   = 0;
        m_pass[i]  = 1;
        m_since[i] = 0;
        issue(i, 0);
      end else if (start && m_mode[i] == 2) begin
        m_mode[i] = 1;
      end else if (m_mode[i] == 1) begin
        m_since[i]++;
        if (m_since[i] == int'(TD)) begin
          m_since[i] = 0;
          if (m_pos[i] < int'(LEN) - 1) begin
            m_pos[i]++;
            issue(i, m_pos[i]);
          end else if (loops_cfg[i] == 0 || m_pass[i] < loops_cfg[i]) begin
            m_pos[i] = 0;
            m_pass[i]++;
            issue(i, 0);
          end else begin
            m_mode[i] = 3;
            m_exp[i]  = 0;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s inst=%0d observed=%0h expected=%0h edge=%0d", tag, i, obs, expv, edge_n);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      chk("chart_addr",  i, 32'(addr_w[i]), 32'(m_addr[i]));
      chk("exp_notes",   i, 32'(exp_w[i]),  32'(m_exp[i]));
      chk("note_strobe", i, 32'(strb_w[i]), 32'(m_strobe[i]));
      chk("beat_pos",    i, 32'(bpos_w[i]), 32'(m_bpos[i]));
      chk("playing",     i, 32'(play_w[i]), 32'(m_mode[i] == 1));
      chk("done",        i, 32'(done_w[i]), 32'(m_mode[i] == 3));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    rom[0] = 5'b00101;
    rom[1] = 5'b01010;
    rom[2] = 5'b10100;
    rom[3] = 5'b11000;
    model_reset();

    // Reset state
    #1;
    check_all();
    run(3);
    #2 resetn = 1'b1;
    run(2);

    // Start pulse, full passes: LOOPS=1 finishes, LOOPS=2 plays twice, LOOPS=0 wraps
    start = 1'b1;
    cyc();
    start = 1'b0;
    run(40);

    // Restart from DONE, pause 10 clocks mid-pass, resume
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    run(6);
    pause = 1'b1;
    run(10);
    pause = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    run(12);

    // Pause and start together while playing
    pause = 1'b1;
    start = 1'b1;
    run(3);
    pause = 1'b0;
    run(2);
    start = 1'b0;
    run(5);

    // stop with start during PLAY, then a lone start replays from the top
    stop = 1'b1;
    start = 1'b1;
    cyc();
    stop = 1'b0;
    start = 1'b0;
    run(2);
    start = 1'b1;
    cyc();
    start = 1'b0;
    run(9);

    // Asynchronous reset pulse mid-play
    #2 resetn = 1'b0;
    model_reset();
    #1;
    check_all();
    cyc();
    #2 resetn = 1'b1;
    run(10);

    // Random command stream
    for (int k = 0; k < 600; k++) begin
      stop  = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      start = ($urandom_range(0, 5) == 0);
      cyc();
    end
    stop  = 1'b0;
    pause = 1'b0;
    start = 1'b0;
    run(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
